// File: rtl/wb_ip_pkg.sv
// Shared register map, control/status/irq bit positions and address decode for the
// IP-side stream FIFO register block.
package wb_ip_pkg;

   localparam logic [15:0] ADDR_DATA   = 16'h0020;
   localparam logic [15:0] ADDR_LEVELS = 16'h0024;
   localparam logic [15:0] ADDR_THRESH = 16'h0028;

   localparam int unsigned CTRL_ENABLE   = 0;
   localparam int unsigned CTRL_TX_FLUSH = 1;
   localparam int unsigned CTRL_RX_FLUSH = 2;

   localparam int unsigned STAT_TX_EMPTY     = 0;
   localparam int unsigned STAT_TX_FULL      = 1;
   localparam int unsigned STAT_RX_EMPTY     = 2;
   localparam int unsigned STAT_RX_FULL      = 3;
   localparam int unsigned STAT_TX_OVERFLOW  = 4;
   localparam int unsigned STAT_RX_UNDERFLOW = 5;

   localparam int unsigned IRQ_TX_LOW       = 0;
   localparam int unsigned IRQ_RX_HIGH      = 1;
   localparam int unsigned IRQ_TX_OVERFLOW  = 2;
   localparam int unsigned IRQ_RX_UNDERFLOW = 3;

   typedef enum logic [1:0] {
      RegData,
      RegLevels,
      RegThresh,
      RegNone
   } reg_sel_e;

   // Anything outside the three mapped words decodes to RegNone (reads 0, writes ignored).
   function automatic reg_sel_e decode_addr(input logic [15:0] addr);
      case (addr)
         ADDR_DATA:   return RegData;
         ADDR_LEVELS: return RegLevels;
         ADDR_THRESH: return RegThresh;
         default:     return RegNone;
      endcase
   endfunction

endpackage

// File: rtl/ip_sync_fifo.sv
// Single-clock FIFO with registered storage and a show-ahead head word.
// Push at full is accepted only when a pop happens in the same cycle; flush wins over both.
module ip_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic [CW-1:0]    o_count,
   output logic             o_empty,
   output logic             o_full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   always_comb begin
      o_empty = (count_q == '0);
      o_full  = (count_q == CW'(DEPTH));
      do_pop  = i_pop && !o_empty;
      // At full the slot being written is the one being popped this cycle.
      do_push = i_push && (!o_full || do_pop);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
   end

   assign o_head  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/wb_ip_stream_fifo.sv
// IP register block bridging bus DATA accesses to TX/RX streaming FIFOs.
// Define WB_IP_FIFO_STALL_ON_FULL_EN to stall instead of dropping/flagging on full/empty.
module wb_ip_stream_fifo
   import wb_ip_pkg::*;
#(
   parameter int unsigned WB_DATA_WIDTH             = 32,
   parameter int unsigned WB_REGISTER_ADDRESS_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH                = 16
) (
   input  logic                                 i_wb_clk,
   input  logic                                 i_wb_rst_n,
   input  logic [WB_REGISTER_ADDRESS_WIDTH-1:0] i_ip_address,
   input  logic [WB_DATA_WIDTH-1:0]             i_ip_wdata,
   output logic [WB_DATA_WIDTH-1:0]             o_ip_rdata,
   input  logic                                 i_ip_read_en,
   input  logic                                 i_ip_write_en,
   output logic                                 o_ip_ack,
   output logic                                 o_ip_stall,
   input  logic [WB_DATA_WIDTH-1:0]             i_ip_control,
   output logic [WB_DATA_WIDTH-1:0]             o_ip_status,
   output logic [WB_DATA_WIDTH-1:0]             o_ip_irq,
   output logic [WB_DATA_WIDTH-1:0]             o_tx_data,
   output logic                                 o_tx_valid,
   input  logic                                 i_tx_ready,
   input  logic [WB_DATA_WIDTH-1:0]             i_rx_data,
   input  logic                                 i_rx_valid,
   output logic                                 o_rx_ready
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   reg_sel_e                 sel;
   logic                     enable, tx_flush, rx_flush;
   logic                     access, complete;
   logic                     data_wr_req, data_rd_req;
   logic                     tx_push, tx_pop, rx_push, rx_pop;
   logic                     tx_empty, tx_full, rx_empty, rx_full;
   logic [CW-1:0]            tx_count, rx_count;
   logic [WB_DATA_WIDTH-1:0] rx_head;
   logic                     tx_overflow_q, rx_underflow_q;
   logic [15:0]              tx_low_q, rx_high_q;
   logic                     unused_ctrl;

   assign enable   = i_ip_control[CTRL_ENABLE];
   assign tx_flush = i_ip_control[CTRL_TX_FLUSH];
   assign rx_flush = i_ip_control[CTRL_RX_FLUSH];
   assign unused_ctrl = ^i_ip_control[WB_DATA_WIDTH-1:3];

   assign sel         = decode_addr(16'(i_ip_address));
   assign access      = i_ip_read_en | i_ip_write_en;
   assign data_wr_req = i_ip_write_en && (sel == RegData);
   // read_en is also high during writes, so a DATA read needs write_en low.
   assign data_rd_req = i_ip_read_en && !i_ip_write_en && (sel == RegData);

   assign o_tx_valid = enable && !tx_flush && !tx_empty;
   assign o_rx_ready = enable && !rx_flush && !rx_full;
   assign tx_pop     = o_tx_valid && i_tx_ready;
   assign rx_push    = i_rx_valid && o_rx_ready;

`ifdef WB_IP_FIFO_STALL_ON_FULL_EN
   // A same-cycle stream drain frees the slot, so a full TX FIFO need not stall then.
   assign o_ip_stall = (data_wr_req && tx_full && !tx_pop) || (data_rd_req && rx_empty);
`else
   assign o_ip_stall = 1'b0;
`endif

   assign complete = access && !o_ip_stall;
   assign o_ip_ack = complete;
   assign tx_push  = complete && data_wr_req;
   assign rx_pop   = complete && data_rd_req;

   ip_sync_fifo #(
      .WIDTH (WB_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .i_clk   (i_wb_clk),
      .i_rst_n (i_wb_rst_n),
      .i_push  (tx_push),
      .i_pop   (tx_pop),
      .i_flush (tx_flush),
      .i_data  (i_ip_wdata),
      .o_head  (o_tx_data),
      .o_count (tx_count),
      .o_empty (tx_empty),
      .o_full  (tx_full)
   );

   ip_sync_fifo #(
      .WIDTH (WB_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .i_clk   (i_wb_clk),
      .i_rst_n (i_wb_rst_n),
      .i_push  (rx_push),
      .i_pop   (rx_pop),
      .i_flush (rx_flush),
      .i_data  (i_rx_data),
      .o_head  (rx_head),
      .o_count (rx_count),
      .o_empty (rx_empty),
      .o_full  (rx_full)
   );

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         tx_overflow_q  <= 1'b0;
         rx_underflow_q <= 1'b0;
      end else begin
         if (tx_flush) begin
            tx_overflow_q <= 1'b0;
         end else if (tx_push && tx_full && !tx_pop) begin
            tx_overflow_q <= 1'b1;
         end
         if (rx_flush) begin
            rx_underflow_q <= 1'b0;
         end else if (rx_pop && rx_empty) begin
            rx_underflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         tx_low_q  <= 16'h0000;
         rx_high_q <= 16'h0001;
      end else if (complete && i_ip_write_en && (sel == RegThresh)) begin
         tx_low_q  <= i_ip_wdata[15:0];
         rx_high_q <= i_ip_wdata[31:16];
      end
   end

   always_comb begin
      o_ip_rdata = '0;
      unique case (sel)
         RegData:   o_ip_rdata = (i_ip_write_en || rx_empty) ? '0 : rx_head;
         RegLevels: o_ip_rdata = WB_DATA_WIDTH'({16'(rx_count), 16'(tx_count)});
         RegThresh: o_ip_rdata = WB_DATA_WIDTH'({rx_high_q, tx_low_q});
         RegNone:   o_ip_rdata = '0;
      endcase
   end

   always_comb begin
      o_ip_status                    = '0;
      o_ip_status[STAT_TX_EMPTY]     = tx_empty;
      o_ip_status[STAT_TX_FULL]      = tx_full;
      o_ip_status[STAT_RX_EMPTY]     = rx_empty;
      o_ip_status[STAT_RX_FULL]      = rx_full;
      o_ip_status[STAT_TX_OVERFLOW]  = tx_overflow_q;
      o_ip_status[STAT_RX_UNDERFLOW] = rx_underflow_q;

      o_ip_irq                   = '0;
      o_ip_irq[IRQ_TX_LOW]       = (16'(tx_count) <= tx_low_q);
      o_ip_irq[IRQ_RX_HIGH]      = (rx_high_q != 16'h0000) && (16'(rx_count) >= rx_high_q);
      o_ip_irq[IRQ_TX_OVERFLOW]  = tx_overflow_q;
      o_ip_irq[IRQ_RX_UNDERFLOW] = rx_underflow_q;
   end

endmodule

// File: tb/tb_wb_ip_stream_fifo.sv
// Directed bench for wb_ip_stream_fifo with TX/RX data scoreboards.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_wb_ip_stream_fifo;

   localparam logic [15:0] A_DATA   = 16'h0020;
   localparam logic [15:0] A_LEVELS = 16'h0024;
   localparam logic [15:0] A_THRESH = 16'h0028;
   localparam logic [15:0] A_NONE   = 16'h0030;

   logic        clk, rst_n;
   logic [15:0] ip_address;
   logic [31:0] ip_wdata, ip_rdata, ip_control, ip_status, ip_irq;
   logic        ip_read_en, ip_write_en, ip_ack, ip_stall;
   logic [31:0] tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] txq[$];
   logic [31:0] rxq[$];
   logic [31:0] rd;

   wb_ip_stream_fifo #(
      .WB_DATA_WIDTH             (32),
      .WB_REGISTER_ADDRESS_WIDTH (16),
      .FIFO_DEPTH                (16)
   ) dut (
      .i_wb_clk      (clk),
      .i_wb_rst_n    (rst_n),
      .i_ip_address  (ip_address),
      .i_ip_wdata    (ip_wdata),
      .o_ip_rdata    (ip_rdata),
      .i_ip_read_en  (ip_read_en),
      .i_ip_write_en (ip_write_en),
      .o_ip_ack      (ip_ack),
      .o_ip_stall    (ip_stall),
      .i_ip_control  (ip_control),
      .o_ip_status   (ip_status),
      .o_ip_irq      (ip_irq),
      .o_tx_data     (tx_data),
      .o_tx_valid    (tx_valid),
      .i_tx_ready    (tx_ready),
      .i_rx_data     (rx_data),
      .i_rx_valid    (rx_valid),
      .o_rx_ready    (rx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every accepted TX beat must match the oldest word written over the bus.
   always @(negedge clk) begin
      #2;
      if (rst_n && tx_valid && tx_ready) begin
         check("tx_q_nonempty", 32'(txq.size() != 0), 32'd1);
         if (txq.size() != 0) check("tx_data", tx_data, txq.pop_front());
      end
   end

   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      int n = 0;
      ip_address  = a;
      ip_wdata    = d;
      ip_read_en  = 1'b1;
      ip_write_en = 1'b1;
      #1;
      while (ip_stall && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wr_ack", ip_ack, 32'd1);
      if (a == A_DATA) check("wr_rdata_zero", ip_rdata, 32'd0);
      @(negedge clk);
      ip_read_en  = 1'b0;
      ip_write_en = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
      int n = 0;
      ip_address  = a;
      ip_read_en  = 1'b1;
      ip_write_en = 1'b0;
      #1;
      while (ip_stall && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rd_ack", ip_ack, 32'd1);
      d = ip_rdata;
      @(negedge clk);
      ip_read_en = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(a, v);
      check(tag, v, exp);
   endtask

   task automatic rx_send(input logic [31:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      #1;
      check("rx_ready", rx_ready, 32'd1);
      if (rx_ready) rxq.push_back(d);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      ip_address = '0; ip_wdata = '0; ip_read_en = 1'b0; ip_write_en = 1'b0;
      ip_control = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_status", ip_status, 32'h5);
      check("rst_irq", ip_irq, 32'h1);
      check("rst_tx_valid", tx_valid, 32'd0);
      check("rst_rx_ready", rx_ready, 32'd0);
      check("rst_stall", ip_stall, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      rd_chk("levels_init", A_LEVELS, 32'h0);
      rd_chk("thresh_init", A_THRESH, 32'h0001_0000);
      rd_chk("unmapped_rd", A_NONE, 32'h0);

      // Single TX word, held back until ENABLE.
      bus_write(A_DATA, 32'hA5A5_0001);
      txq.push_back(32'hA5A5_0001);
      rd_chk("levels_tx1", A_LEVELS, 32'h0000_0001);
      check("tx_valid_disabled", tx_valid, 32'd0);
      check("irq_tx1", ip_irq, 32'h0);
      ip_control = 32'h1;
      #1;
      check("tx_valid_enabled", tx_valid, 32'd1);
      check("tx_data_head", tx_data, 32'hA5A5_0001);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      rd_chk("levels_drained", A_LEVELS, 32'h0);
      check("irq_tx_low", ip_irq, 32'h1);
      check("tx_q_empty", 32'(txq.size()), 32'd0);

      // RX stream into bus reads with rx_high = 3.
      bus_write(A_THRESH, 32'h0003_0000);
      rd_chk("thresh_wr", A_THRESH, 32'h0003_0000);
      rx_send(32'h11);
      rx_send(32'h22);
      check("irq_rx_below", ip_irq, 32'h1);
      rx_send(32'h33);
      check("irq_rx_high", ip_irq, 32'h3);
      rd_chk("levels_rx3", A_LEVELS, 32'h0003_0000);
      for (int i = 0; i < 3; i++) begin
         bus_read(A_DATA, rd);
         check("rx_data", rd, rxq.pop_front());
      end
      check("status_rx_empty", ip_status, 32'h5);

`ifndef WB_IP_FIFO_STALL_ON_FULL_EN
      // Read from empty RX: returns 0 and sets the sticky underflow.
      rd_chk("rx_underflow_rd", A_DATA, 32'h0);
      check("status_underflow", ip_status, 32'h25);
      check("irq_underflow", ip_irq, 32'h9);
      ip_control = 32'h5;
      @(negedge clk);
      ip_control = 32'h1;
      check("status_rx_flushed", ip_status, 32'h5);
`endif

      // Fill TX to 16 with the stream disabled.
      ip_control = 32'h0;
      for (int i = 0; i < 16; i++) begin
         bus_write(A_DATA, 32'h1000 + 32'(i));
         txq.push_back(32'h1000 + 32'(i));
      end
      rd_chk("levels_full", A_LEVELS, 32'h10);
      check("status_full", ip_status, 32'h6);

      // Bus push and stream drain in the same cycle at full.
      ip_control = 32'h1;
      tx_ready   = 1'b1;
      bus_write(A_DATA, 32'h2000);
      txq.push_back(32'h2000);
      tx_ready   = 1'b0;
      ip_control = 32'h0;
      rd_chk("levels_full_pushpop", A_LEVELS, 32'h10);
      check("status_no_ovf", ip_status, 32'h6);

`ifndef WB_IP_FIFO_STALL_ON_FULL_EN
      bus_write(A_DATA, 32'h3000);
      rd_chk("levels_after_drop", A_LEVELS, 32'h10);
      check("status_ovf", ip_status, 32'h16);
      check("irq_ovf", ip_irq, 32'h4);
`else
      ip_address  = A_DATA;
      ip_wdata    = 32'h3000;
      ip_read_en  = 1'b1;
      ip_write_en = 1'b1;
      #1;
      check("stall_full", ip_stall, 32'd1);
      check("ack_stalled", ip_ack, 32'd0);
      @(negedge clk);
      #1;
      check("stall_hold", ip_stall, 32'd1);
      @(negedge clk);
      ip_control = 32'h1;
      tx_ready   = 1'b1;
      #1;
      check("stall_released", ip_stall, 32'd0);
      check("ack_released", ip_ack, 32'd1);
      txq.push_back(32'h3000);
      @(negedge clk);
      ip_read_en  = 1'b0;
      ip_write_en = 1'b0;
      tx_ready    = 1'b0;
      ip_control  = 32'h0;
      rd_chk("levels_after_stall", A_LEVELS, 32'h10);
      check("status_stall_no_ovf", ip_status, 32'h6);
`endif

      // Drain four words (order checked by the scoreboard), then flush the rest.
      ip_control = 32'h1;
      tx_ready   = 1'b1;
      repeat (4) @(negedge clk);
      tx_ready   = 1'b0;
      ip_control = 32'h0;
      rd_chk("levels_drain4", A_LEVELS, 32'h0C);
      ip_control = 32'h2;
      @(negedge clk);
      txq.delete();
      ip_control = 32'h0;
      rd_chk("levels_flushed", A_LEVELS, 32'h0);
      check("status_flushed", ip_status, 32'h5);

      // Reset asserted in the middle of stream traffic.
      ip_control = 32'h1;
      bus_write(A_DATA, 32'h4000);
      txq.push_back(32'h4000);
      bus_write(A_DATA, 32'h4001);
      txq.push_back(32'h4001);
      tx_ready = 1'b1;
      rx_send(32'h55);
      rst_n      = 1'b0;
      ip_control = 32'h0;
      txq.delete();
      rxq.delete();
      #1;
      check("midrst_tx_valid", tx_valid, 32'd0);
      check("midrst_status", ip_status, 32'h5);
      check("midrst_irq", ip_irq, 32'h1);
      check("midrst_rx_ready", rx_ready, 32'd0);
      tx_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd_chk("levels_post_rst", A_LEVELS, 32'h0);
      rd_chk("thresh_post_rst", A_THRESH, 32'h0001_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
